// File: rtl/bram_delay_pkg.sv
// Shared types and helpers for the runtime-programmable BRAM delay controller.
package bram_delay_pkg;
    localparam int ADDR_W_DEFAULT = 8;
    localparam int DEPTH = 1 << ADDR_W_DEFAULT;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Read and write addresses can never coincide inside this window.
    function automatic logic delay_legal(input int d, input int addr_w, input int latency);
        return (d >= latency + 1) && (d <= (1 << addr_w) - 1 + latency);
    endfunction
endpackage

// File: rtl/bram_delay_ctrl_valid_pipe.sv
// ce-gated single-bit shift register; matches a flag to a fixed ce-step latency.
module valid_pipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic din,
    output logic dout
);
    logic [STAGES-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (ce) begin
            pipe_d[0] = din;
            for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end

    assign dout = pipe_q[STAGES-1];
endmodule

// File: rtl/bram_delay_ctrl.sv
// Ring-buffer address/valid sequencer for a simple dual-port BRAM delay line.
// FILL: not enough history for the active delay; RUN: history sufficient, config accepted.
module bram_delay_ctrl
    import bram_delay_pkg::*;
#(
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int LATENCY       = 2,
    parameter int DEFAULT_DELAY = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W:0]   cfg_delay,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic              bram_re,
    output logic [ADDR_W-1:0] bram_raddr,
    output logic              dout_valid,
    output logic [ADDR_W:0]   cur_delay
);
    localparam int              DEPTH_N   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAT_W     = (ADDR_W+1)'(LATENCY);
    localparam logic [ADDR_W:0] HIST_MAX  = (ADDR_W+1)'(DEPTH_N);
    localparam logic [ADDR_W:0] DELAY_RST = (ADDR_W+1)'(DEFAULT_DELAY);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   hist_q, hist_d;
    logic [ADDR_W:0]   delay_q, delay_d;
    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   span, cfg_span;
    logic              rvalid, accept, cfg_ok;

    // span = how far the read pointer trails the write pointer
    assign span     = delay_q - LAT_W;
    assign cfg_span = cfg_delay - LAT_W;
    assign rvalid   = (hist_q >= span);
    assign accept   = cfg_valid & cfg_ready;
    assign cfg_ok   = delay_legal(int'(cfg_delay), ADDR_W, LATENCY);

    always_comb begin
        wptr_d  = wptr_q;
        hist_d  = hist_q;
        delay_d = delay_q;
        state_d = state_q;
        err_d   = 1'b0;
        if (ce) begin
            wptr_d = wptr_q + 1'b1;
            if (hist_q != HIST_MAX) hist_d = hist_q + 1'b1;
        end
        if (state_q == FILL && rvalid) state_d = RUN;
        // History is kept across a delay change, so only missing history forces FILL.
        if (accept) begin
            if (cfg_ok) begin
                delay_d = cfg_delay;
                state_d = (hist_q >= cfg_span) ? RUN : FILL;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            hist_q  <= '0;
            delay_q <= DELAY_RST;
            state_q <= FILL;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            hist_q  <= hist_d;
            delay_q <= delay_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    valid_pipe #(.STAGES(LATENCY)) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .din  (rvalid),
        .dout (dout_valid)
    );

    assign bram_we    = ce & ~rst;
    assign bram_re    = ce & ~rst;
    assign bram_waddr = wptr_q;
    assign bram_raddr = wptr_q - span[ADDR_W-1:0];
    assign cfg_ready  = (state_q == RUN);
    assign cfg_err    = err_q;
    assign cur_delay  = delay_q;
endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Directed bench: controller plus behavioural BRAM, checked against a written-sample scoreboard.
module tb_bram_delay_ctrl;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int DEF = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [AW:0]   cfg_delay = '0;
    logic          cfg_ready, cfg_err, bram_we, bram_re, dout_valid;
    logic [AW-1:0] bram_waddr, bram_raddr;
    logic [AW:0]   cur_delay;

    logic [15:0] din = '0;
    logic [15:0] mem [256];
    logic [15:0] rd1, dout;

    int checks = 0;
    int failures = 0;
    int steps = 0;
    int d_mod = DEF;
    int settle = 0;
    int acc_step = -1;
    bit err_exp = 1'b0;
    bit last_acc = 1'b0;
    int wq[$];

    always #5 clk = ~clk;

    bram_delay_ctrl #(.ADDR_W(AW), .LATENCY(LAT), .DEFAULT_DELAY(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .cfg_delay  (cfg_delay),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .bram_we    (bram_we),
        .bram_waddr (bram_waddr),
        .bram_re    (bram_re),
        .bram_raddr (bram_raddr),
        .dout_valid (dout_valid),
        .cur_delay  (cur_delay)
    );

    // Read latency LAT=2: address register stage then output register stage.
    always_ff @(posedge clk) begin
        if (bram_we) mem[bram_waddr] <= din;
        if (bram_re) begin
            rd1  <= mem[bram_raddr];
            dout <= rd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: sample/check at negedge, then update the model after the posedge.
    task automatic step();
        bit acc;
        int req;
        din = 16'(steps);
        @(negedge clk);
        acc = cfg_valid && cfg_ready && !rst;
        req = int'(cfg_delay);
        if (!rst) begin
            chk("waddr", 32'(bram_waddr), 32'(steps % 256));
            chk("raddr", 32'(bram_raddr), 32'((steps - (d_mod - LAT)) & 255));
            chk("we", 32'(bram_we), 32'(ce));
            chk("cfg_err", 32'(cfg_err), 32'(err_exp));
            chk("cur_delay", 32'(cur_delay), 32'(d_mod));
            if (settle == 0) begin
                chk("dout_valid", 32'(dout_valid), 32'(steps >= d_mod));
                if (steps >= d_mod) chk("dout", 32'(dout), 32'(wq[wq.size() - d_mod]));
            end
        end
        @(posedge clk);
        #1;
        last_acc = acc;
        if (rst) begin
            steps = 0;
            wq.delete();
            d_mod = DEF;
            settle = 0;
            err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (ce && settle > 0) settle--;
            if (acc) begin
                acc_step = steps;
                if (req >= LAT + 1 && req <= 255 + LAT) begin
                    d_mod = req;
                    settle = LAT;
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (ce) begin
                wq.push_back(steps);
                if (wq.size() > 300) void'(wq.pop_front());
                steps++;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, "_delay"}, 32'(cur_delay), 32'(DEF));
    endtask

    initial begin
        int bad_list[2];
        bad_list[0] = 2;
        bad_list[1] = 258;

        // Reset, then continuous ce with the default delay.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ce = 1'b1;
        check_reset_state("init");
        while (steps < 300) begin
            step();
            if (steps == 126) chk("ready_fill", 32'(cfg_ready), 32'd0);
            if (steps == 127) chk("ready_run", 32'(cfg_ready), 32'd1);
            if (steps == 128) begin
                chk("first_valid", 32'(dout_valid), 32'd1);
                chk("first_dout", 32'(dout), 32'd0);
            end
        end

        // Shorten to 10 while running.
        cfg_delay = 9'd10;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("short_acc", 32'(last_acc), 32'd1);
        chk("short_step", 32'(acc_step), 32'd300);
        chk("short_ready", 32'(cfg_ready), 32'd1);
        repeat (LAT) begin
            chk("short_hold", 32'(dout_valid), 32'd1);
            step();
        end
        repeat (20) step();

        // Out-of-range requests are accepted but rejected.
        foreach (bad_list[i]) begin
            cfg_delay = 9'(bad_list[i]);
            cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
            chk("bad_acc", 32'(last_acc), 32'd1);
            chk("bad_err_pulse", 32'(cfg_err), 32'd1);
            chk("bad_delay", 32'(cur_delay), 32'd10);
            repeat (5) step();
        end

        // Mid-run reset.
        while (steps < 400) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (135) step();

        // Random ce: the stream follows ce-step count, pointers freeze otherwise.
        repeat (400) begin
            ce = 1'($urandom_range(0, 1));
            step();
        end
        ce = 1'b1;

        // Lengthen to 200 requested while still filling; held until ready.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (50) step();
        cfg_delay = 9'd200;
        cfg_valid = 1'b1;
        step();
        chk("long_pending", 32'(last_acc), 32'd0);
        for (int i = 0; i < 400 && !last_acc; i++) step();
        cfg_valid = 1'b0;
        chk("long_acc", 32'(last_acc), 32'd1);
        chk("long_step", 32'(acc_step), 32'd127);
        chk("long_fill", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 400 && steps < 199; i++) step();
        chk("long_run", 32'(cfg_ready), 32'd1);
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bram_delay_ctrl.md
Name: bram_delay_ctrl

Overview:
- Address and valid sequencer for a simple dual-port BRAM used as a runtime-programmable delay line.
- Serves the X-engine datapath where a fixed-parameter BRAM delay is insufficient, e.g. per-antenna delay compensation.
- Continuous ring-buffer writes; read address trails the write address by the programmed delay.
- Delay reprogrammed at runtime via a valid/ready handshake; output-valid flag aligned with BRAM read data.

Parameters:
- ADDR_W, 8: BRAM address width; DEPTH = 2^ADDR_W.
- LATENCY, 2: BRAM read latency in ce-steps, from raddr to dout.
- DEFAULT_DELAY, 128: delay loaded at reset; must lie in the legal range.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; one sample step per ce-high cycle
- cfg_delay  in  ADDR_W+1  requested delay in samples
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted
- cfg_err  out  1  one-cycle pulse: accepted request was out of range
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_W  BRAM write address
- bram_re  out  1  BRAM read enable / output register enable
- bram_raddr  out  ADDR_W  BRAM read address
- dout_valid  out  1  BRAM dout holds a sample genuinely delayed by delay_reg
- cur_delay  out  ADDR_W+1  active delay register

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - wptr=0, hist_cnt=0, delay_reg=DEFAULT_DELAY, state=FILL.
  - Valid pipeline cleared; cfg_err=0.
  - Overrides ce and cfg_valid in the same cycle; a mid-operation reset discards all history.
- Legal delay range: LATENCY+1 <= D <= DEPTH-1+LATENCY.
  - Read and write addresses never coincide, so BRAM collision mode is irrelevant.
- Addressing (combinational from registers):
  - bram_we = bram_re = ce & ~rst.
  - bram_waddr = wptr.
  - bram_raddr = (wptr - (delay_reg - LATENCY)) mod DEPTH.
  - wptr increments on each ce step and wraps DEPTH-1 -> 0.
- End-to-end delay: a sample written on step n appears on BRAM dout at step n+D.
- History counter:
  - hist_cnt is ADDR_W+1 bits, +1 per ce step, saturating at DEPTH.
  - rvalid = (hist_cnt >= delay_reg - LATENCY), evaluated at the read step.
  - rvalid shifts through a LATENCY-deep pipeline advanced only on ce; dout_valid = pipeline output.
- FSM, two states:
  - FILL: cfg_ready=0. Moves to RUN on the first cycle where rvalid=1.
  - RUN: cfg_ready=1.
- Config acceptance (cfg_valid & cfg_ready), legal cfg_delay:
  - delay_reg <= cfg_delay; the new raddr takes effect next cycle.
  - Next state = RUN if hist_cnt >= cfg_delay-LATENCY, else FILL.
  - History is retained, so shortening the delay is instant and lengthening waits only for the missing history.
- Config acceptance, illegal cfg_delay:
  - cfg_err=1 for one cycle; delay_reg and state unchanged.
  - Handshake still completes.
- Same-cycle ce and acceptance: that cycle's read uses the old delay.
  - Pipelined dout_valid flags already issued are unaffected.
  - Output may show a discontinuity; it is not invalidated.
- ce=0 freezes wptr, hist_cnt and the valid pipeline; config acceptance still proceeds.
- cfg_valid while cfg_ready=0 is held pending; no state change until ready.

Decomposition:
- Shared package (bram_delay_pkg) holds:
  - state encoding (FILL, RUN);
  - function delay_legal(D, ADDR_W, LATENCY);
  - localparam DEPTH.
- One natural sub-module: valid_pipe.
  - A ce-gated single-bit shift register of depth LATENCY, synchronous reset.
  - Reusable by other latency-matching blocks.
- Bench pairs the controller with a behavioural dual-port BRAM model of read latency LATENCY.

Test Plan (ADDR_W=8, LATENCY=2, DEFAULT_DELAY=128, din = sample counter ctr):
- Reset then ce=1 continuously:
  - dout_valid first high at step 128 with dout=0;
  - thereafter dout = ctr-128 every step;
  - bram_waddr wraps 255 -> 0 without glitch.
- In RUN at step 300, program cfg_delay=10:
  - accepted immediately, state stays RUN;
  - within 2 steps dout = ctr-10, dout_valid stays 1.
- Reset, wait 50 steps, program 200 (rejected, FILL), hold cfg_valid:
  - accepted at step 127 when state reaches RUN;
  - state returns to FILL until hist_cnt >= 198;
  - then dout = ctr-200.
- In RUN, cfg_delay=2 and again cfg_delay=258:
  - each produces a cfg_err pulse;
  - cur_delay unchanged, output stream unchanged.
- Toggle ce 50% random:
  - dout = (ce-step count) - 128;
  - wptr/hist_cnt frozen on ce=0 cycles.
- Assert rst for 1 cycle at step 400 in RUN:
  - next cycle dout_valid=0, state=FILL, cur_delay=128;
  - valid resumes 128 ce steps later.
